// File: rtl/phy_init_sequencer.sv
// PHY power-up sequencer: reset hold, post-reset wait, MDIO init engine start/run, done/error.
// Optional watchdog with bounded restarts is enabled by defining PHY_INIT_WATCHDOG_EN.
module phy_init_sequencer #(
    parameter int unsigned RESET_HOLD      = 50000,
    parameter int unsigned POST_RESET_WAIT = 250000,
    parameter int unsigned TIMEOUT         = 2000000,
    parameter int unsigned MAX_RETRY       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  comm_addr,
    input  logic        ini_end,
    output logic        phy_rst_n,
    output logic        sub_reset,
    output logic        ini_start,
    output logic [31:0] command,
    output logic [15:0] command_and,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_out
);

    // Zero-length phases still last one cycle.
    localparam int unsigned HOLD_LIM = (RESET_HOLD == 0) ? 1 : RESET_HOLD;
    localparam int unsigned WAIT_LIM = (POST_RESET_WAIT == 0) ? 1 : POST_RESET_WAIT;
    localparam int unsigned RUN_LIM  = (TIMEOUT == 0) ? 1 : TIMEOUT;
    localparam int unsigned MAX_HW   = (HOLD_LIM > WAIT_LIM) ? HOLD_LIM : WAIT_LIM;
    localparam int unsigned CNT_MAX  = (MAX_HW > RUN_LIM) ? MAX_HW : RUN_LIM;
    localparam int          CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LIM - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIM - 1);

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       outs;

`ifdef PHY_INIT_WATCHDOG_EN
    localparam int               RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LIM - 1);
    logic [RETRY_W-1:0] retry;
`endif

    // Output bundle {phy_rst_n, sub_reset, ini_start, done, error} loaded with each state change.
    function automatic logic [4:0] outs_for(input state_t s);
        logic err;
`ifdef PHY_INIT_WATCHDOG_EN
        err = (s == S_ERROR);
`else
        err = 1'b0;
`endif
        return {!(s == S_HOLD || s == S_ERROR),
                (s == S_HOLD || s == S_WAIT || s == S_ERROR),
                (s == S_START),
                (s == S_DONE),
                err};
    endfunction

    function automatic logic [31:0] table_word(input logic [3:0] a);
        case (a)
            4'd0:    return 32'hC000_8000;
            4'd1:    return 32'hC400_8000;
            4'd2:    return 32'hC280_0082;
            4'd3:    return 32'hC680_0082;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign {phy_rst_n, sub_reset, ini_start, done, error} = outs;
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HOLD;
            cnt         <= '0;
            outs        <= outs_for(S_HOLD);
            command     <= '0;
            command_and <= 16'hFFFF;
`ifdef PHY_INIT_WATCHDOG_EN
            retry       <= '0;
`endif
        end else begin
            command     <= table_word(comm_addr);
            command_and <= 16'hFFFF;
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                        outs  <= outs_for(S_WAIT);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= S_START;
                        outs  <= outs_for(S_START);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_RUN;
                    outs  <= outs_for(S_RUN);
                end
                S_RUN: begin
                    // ini_end on the timeout cycle still completes the sequence.
                    if (ini_end) begin
                        cnt   <= '0;
                        state <= S_DONE;
                        outs  <= outs_for(S_DONE);
                    end
`ifdef PHY_INIT_WATCHDOG_EN
                    else if (cnt == RUN_LAST) begin
                        cnt <= '0;
                        if (32'(retry) < MAX_RETRY) begin
                            retry <= retry + 1'b1;
                            state <= S_HOLD;
                            outs  <= outs_for(S_HOLD);
                        end else begin
                            state <= S_ERROR;
                            outs  <= outs_for(S_ERROR);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= S_HOLD;
                        outs  <= outs_for(S_HOLD);
`ifdef PHY_INIT_WATCHDOG_EN
                        retry <= '0;
`endif
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_HOLD;
                    outs  <= outs_for(S_HOLD);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_init_sequencer.sv
// Bench for phy_init_sequencer: elapsed-time reference model, randomized inputs, per-cycle output checks.
module tb_phy_init_sequencer;

    localparam int RH = 4;
    localparam int PW = 6;
    localparam int TO = 20;
    localparam int MR = 2;
`ifdef PHY_INIT_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  comm_addr;
    logic        ini_end;
    logic        phy_rst_n;
    logic        sub_reset;
    logic        ini_start;
    logic [31:0] command;
    logic [15:0] command_and;
    logic        done;
    logic        error;
    logic [2:0]  state_out;

    phy_init_sequencer #(
        .RESET_HOLD     (RH),
        .POST_RESET_WAIT(PW),
        .TIMEOUT        (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .comm_addr  (comm_addr),
        .ini_end    (ini_end),
        .phy_rst_n  (phy_rst_n),
        .sub_reset  (sub_reset),
        .ini_start  (ini_start),
        .command    (command),
        .command_and(command_and),
        .done       (done),
        .error      (error),
        .state_out  (state_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: t = clock edges since the sequence (re)started; st 0=sequencing, 1=done, 2=error.
    int t;
    int st;
    int retries;
    logic [31:0] table_mem [16];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected state code derived from elapsed time in the sequence.
    function automatic int phase();
        if (st == 1) return 4;
        if (st == 2) return 5;
        if (t < RH) return 0;
        if (t < RH + PW) return 1;
        if (t == RH + PW) return 2;
        return 3;
    endfunction

    task automatic model_step();
        int ph;
        ph = phase();
        if (reset) begin
            t = 0; st = 0; retries = 0;
        end else if (st != 0) begin
            if (start) begin
                t = 0; st = 0; retries = 0;
            end
        end else if (ph == 3 && ini_end) begin
            st = 1;
        end else if (WD && ph == 3 && (t - (RH + PW + 1)) == TO - 1) begin
            if (retries < MR) begin
                retries++;
                t = 0;
            end else begin
                st = 2;
            end
        end else begin
            t++;
        end
        if (reset) exp_q.push_back(32'h0);
        else exp_q.push_back(table_mem[comm_addr]);
    endtask

    task automatic check_outputs();
        int ph;
        logic [31:0] exp_cmd;
        ph = phase();
        check("state_out", 32'(state_out), 32'(ph));
        check("phy_rst_n", 32'(phy_rst_n), 32'(!(ph == 0 || ph == 5)));
        check("sub_reset", 32'(sub_reset), 32'(ph == 0 || ph == 1 || ph == 5));
        check("ini_start", 32'(ini_start), 32'(ph == 2));
        check("done", 32'(done), 32'(ph == 4));
        check("error", 32'(error), 32'(ph == 5));
        exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("command", command, exp_cmd);
        check("command_and", 32'(command_and), 32'h0000_FFFF);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // driver
    task automatic drive(input bit rst, input bit s, input bit e);
        reset     = rst;
        start     = s;
        ini_end   = e;
        comm_addr = 4'($urandom_range(0, 15));
    endtask

    task automatic run_until_run();
        int n;
        n = 0;
        while (phase() != 3 && n < 200) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            tick();
            n++;
        end
        check("reach_run", 32'(state_out), 32'd3);
    endtask

    initial begin
        int first_high;
        int start_idx;
        int n_pulse;
        checks = 0; errors = 0;
        t = 0; st = 0; retries = 0;
        for (int i = 0; i < 16; i++) table_mem[i] = 32'h0;
        table_mem[0] = 32'hC000_8000;
        table_mem[1] = 32'hC400_8000;
        table_mem[2] = 32'hC280_0082;
        table_mem[3] = 32'hC680_0082;

        drive(1'b1, 1'b0, 1'b1);
        repeat (3) tick();

        // Power-up: start toggles and ini_end stays low; ini_end pulsed 5 cycles after ini_start.
        first_high = -1; start_idx = -1; n_pulse = 0;
        for (int i = 0; i < RH + PW + 4; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            tick();
            if (phy_rst_n && first_high < 0) first_high = i;
            if (ini_start) begin
                n_pulse++;
                start_idx = i;
            end
        end
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("release_cycle", 32'(first_high), 32'(RH - 1));
        check("ini_start_cycle", 32'(start_idx), 32'(RH + PW - 1));
        check("ini_start_pulses", 32'(n_pulse), 32'd1);
        check("done_after_ini_end", 32'(done), 32'd1);

        // Table stepping 0..5.
        for (int a = 0; a < 6; a++) begin
            drive(1'b0, 1'b0, 1'b0);
            comm_addr = 4'(a);
            tick();
        end

        // Restart from DONE, then random traffic with occasional resets.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 7) == 0));
            tick();
        end

        // Reset two cycles into RUN, with start pulses there ignored.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        run_until_run();
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        check("run_ignores_start", 32'(state_out), 32'd3);
        drive(1'b1, 1'b0, 1'b0);
        tick();
        check("mid_run_reset_state", 32'(state_out), 32'd0);
        check("mid_run_reset_phy", 32'(phy_rst_n), 32'd0);
        run_until_run();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("done_after_restart", 32'(done), 32'd1);

`ifdef PHY_INIT_WATCHDOG_EN
        drive(1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3 * (RH + PW + 1 + TO) + 10; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        check("wd_error", 32'(error), 32'd1);
        check("wd_phy_rst_n", 32'(phy_rst_n), 32'd0);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check("error_cleared", 32'(error), 32'd0);
        run_until_run();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("done_after_error", 32'(done), 32'd1);
`else
        drive(1'b0, 1'b1, 1'b0);
        tick();
        run_until_run();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        check("no_wd_stays_run", 32'(state_out), 32'd3);
        check("no_wd_error", 32'(error), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
